// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI frame sequencer: state encoding and byte formatting.
package spi_seq_pkg;

  localparam int unsigned VAL_W  = 14;
  localparam logic [1:0]  HI_PAD = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSend0,
    StWait0,
    StGap,
    StSend1,
    StWait1,
    StHold
  } seq_state_t;

  // High byte of a counter snapshot: top six value bits behind a zero pad.
  function automatic logic [7:0] hi_byte(logic [VAL_W-1:0] v);
    return {HI_PAD, v[VAL_W-1:8]};
  endfunction

endpackage

// File: rtl/spi_frame_sequencer_if.sv
// Byte-engine side of the sequencer: byte data, start/done handshake and slave select.
interface spi_frame_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic       ss_n;

  modport master (output tx_data, output tx_start, output ss_n, input tx_done);
  modport slave  (input tx_data, input tx_start, input ss_n, output tx_done);
endinterface

// File: rtl/spi_seq_delay.sv
// 8-bit load/count-down timer; zero is high once the loaded count has run out.
module spi_seq_delay (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_frame_sequencer.sv
// Frames each new 14-bit counter value as a two-byte SPI transaction, coalescing updates that
// arrive while a frame is in flight.
module spi_frame_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned BYTE_GAP = 2,
  parameter int unsigned CS_HOLD  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  clear,
  input  logic [VAL_W-1:0]      value,
  input  logic                  value_upd,
  input  logic                  overrun_clr,
  spi_frame_sequencer_if.master spi,
  output logic                  busy,
  output logic [7:0]            frame_cnt,
  output logic                  overrun
);

  // Timer reload values are one less than the phase length: the load cycle counts as the first.
  localparam logic [7:0] SetupLd = 8'(CS_SETUP - 1);
  localparam logic [7:0] GapLd   = (BYTE_GAP > 0) ? 8'(BYTE_GAP - 1) : 8'd0;
  localparam logic [7:0] HoldLd  = 8'(CS_HOLD - 1);

  seq_state_t       state_q, state_d;
  logic [VAL_W-1:0] pend_val_q, pend_val_d, snap_q, snap_d, load_val;
  logic             pend_flag_q, pend_flag_d, overrun_q, overrun_d;
  logic [7:0]       tx_data_q, tx_data_d, frame_cnt_q, frame_cnt_d, tmr_val;
  logic             tx_start_q, tx_start_d, ss_n_q, ss_n_d, busy_q, busy_d;
  logic             load_any, consume, tmr_load, tmr_zero;

  assign load_any = clear | (value_upd & run);
  assign load_val = clear ? '0 : value;
  assign consume  = (state_q == StIdle) & pend_flag_q;

  always_comb begin
    pend_val_d  = pend_val_q;
    pend_flag_d = pend_flag_q;
    overrun_d   = overrun_q;
    if (consume) pend_flag_d = 1'b0;
    // A load in the consume cycle refills the slot without counting as an overrun.
    if (load_any) begin
      pend_val_d  = load_val;
      pend_flag_d = 1'b1;
    end
    if (overrun_clr) overrun_d = 1'b0;
    if (load_any && pend_flag_q && !consume) overrun_d = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    tmr_load    = 1'b0;
    tmr_val     = 8'd0;
    unique case (state_q)
      StIdle: if (pend_flag_q) begin
        snap_d   = pend_val_q;
        tmr_load = 1'b1;
        tmr_val  = SetupLd;
        state_d  = StSetup;
      end
      StSetup: if (tmr_zero) begin
        state_d    = StSend0;
        tx_start_d = 1'b1;
        tx_data_d  = hi_byte(snap_q);
      end
      StSend0: state_d = StWait0;
      StWait0: if (spi.tx_done) begin
        if (BYTE_GAP == 0) begin
          state_d    = StSend1;
          tx_start_d = 1'b1;
          tx_data_d  = snap_q[7:0];
        end else begin
          state_d  = StGap;
          tmr_load = 1'b1;
          tmr_val  = GapLd;
        end
      end
      StGap: if (tmr_zero) begin
        state_d    = StSend1;
        tx_start_d = 1'b1;
        tx_data_d  = snap_q[7:0];
      end
      StSend1: state_d = StWait1;
      StWait1: if (spi.tx_done) begin
        state_d  = StHold;
        tmr_load = 1'b1;
        tmr_val  = HoldLd;
      end
      StHold: if (tmr_zero) begin
        state_d     = StIdle;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase
    ss_n_d = (state_d == StIdle);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pend_val_q  <= '0;
      pend_flag_q <= 1'b0;
      snap_q      <= '0;
      overrun_q   <= 1'b0;
      tx_data_q   <= 8'd0;
      tx_start_q  <= 1'b0;
      ss_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      pend_val_q  <= pend_val_d;
      pend_flag_q <= pend_flag_d;
      snap_q      <= snap_d;
      overrun_q   <= overrun_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      ss_n_q      <= ss_n_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  spi_seq_delay u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign spi.tx_data  = tx_data_q;
  assign spi.tx_start = tx_start_q;
  assign spi.ss_n     = ss_n_q;
  assign busy         = busy_q;
  assign frame_cnt    = frame_cnt_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench for spi_frame_sequencer: directed scenarios plus randomized updates.
module tb_spi_frame_sequencer;

  localparam int unsigned CS_SETUP = 4;
  localparam int unsigned BYTE_GAP = 2;
  localparam int unsigned CS_HOLD  = 4;

  logic        clk = 1'b0, reset = 1'b0, run = 1'b0, clear = 1'b0;
  logic        value_upd = 1'b0, overrun_clr = 1'b0;
  logic [13:0] value = '0;
  logic        busy, overrun;
  logic [7:0]  frame_cnt;

  spi_frame_sequencer_if sif ();

  spi_frame_sequencer #(
    .CS_SETUP (CS_SETUP),
    .BYTE_GAP (BYTE_GAP),
    .CS_HOLD  (CS_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .clear       (clear),
    .value       (value),
    .value_upd   (value_upd),
    .overrun_clr (overrun_clr),
    .spi         (sif),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0, n_fail = 0;
  // Reference model: queue of values expected on the wire, and whether the tail is still pending.
  logic [13:0] exp_q[$];
  logic        slot_full = 1'b0;
  logic        exp_ovr = 1'b0;
  int unsigned exp_cnt = 0;

  int unsigned cyc = 0, fall_cyc = 0, done_cyc = 0, high_len = 0, last_gap = 0;
  int unsigned n_falls = 0, n_starts = 0, n_frames = 0, nbytes = 0;
  int unsigned lat_lo = 5, lat_hi = 20;
  logic [7:0]  b0 = '0, b1 = '0, held = '0;
  logic        in_frame = 1'b0, waiting = 1'b0, ss_prev = 1'b1, prev_start = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_load(input logic [13:0] v);
    if (slot_full) begin
      exp_q[exp_q.size() - 1] = v;
      exp_ovr = 1'b1;
    end else begin
      exp_q.push_back(v);
      slot_full = 1'b1;
    end
  endfunction

  task automatic do_load(input logic upd, input logic clr, input logic [13:0] v,
                         output int unsigned t);
    @(posedge clk); #1;
    value     = v;
    value_upd = upd;
    clear     = clr;
    t         = cyc + 1;
    @(posedge clk); #1;
    value_upd = 1'b0;
    clear     = 1'b0;
    if (clr || (upd && run)) model_load(clr ? 14'd0 : v);
  endtask

  task automatic pulse_ovr_clr();
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
  endtask

  task automatic wait_falls(input int unsigned target);
    int unsigned k = 0;
    while (n_falls < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (n_falls < target) check("frame_start_timeout", n_falls, target);
  endtask

  task automatic wait_starts(input int unsigned target);
    int unsigned k = 0;
    while (n_starts < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (n_starts < target) check("tx_start_timeout", n_starts, target);
  endtask

  task automatic wait_drain();
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Byte engine: answers each start with a done pulse after a random latency.
  initial begin
    int unsigned lat;
    sif.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && sif.tx_start) begin
        lat = $urandom_range(lat_hi, lat_lo);
        repeat (lat) @(posedge clk);
        #1 sif.tx_done = 1'b1;
        @(posedge clk);
        #1 sif.tx_done = 1'b0;
      end
    end
  end

  // Monitor: reassembles frames from the wire, checks spacing, and scores against the model.
  initial begin
    int unsigned ev;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        in_frame = 1'b0; waiting = 1'b0; ss_prev = 1'b1; prev_start = 1'b0;
        high_len = 0; exp_cnt = 0; nbytes = 0;
      end else begin
        if (ss_prev && !sif.ss_n) begin
          n_falls++;
          last_gap = high_len;
          in_frame = 1'b1;
          nbytes   = 0;
          fall_cyc = cyc;
        end
        if (sif.tx_start) begin
          n_starts++;
          check("tx_start_width", prev_start, 0);
          check("tx_start_in_frame", in_frame && nbytes < 2, 1);
          if (nbytes == 0) begin
            check("cs_setup_spacing", cyc - fall_cyc, CS_SETUP);
            b0 = sif.tx_data;
          end else begin
            check("byte_gap_spacing", cyc - done_cyc, BYTE_GAP + 1);
            b1 = sif.tx_data;
          end
          nbytes++;
          waiting = 1'b1;
          held    = sif.tx_data;
        end else if (waiting) begin
          check("tx_data_stable", sif.tx_data, held);
        end
        if (waiting && sif.tx_done) begin
          waiting  = 1'b0;
          done_cyc = cyc;
        end
        if (!ss_prev && sif.ss_n && in_frame) begin
          in_frame = 1'b0;
          check("cs_hold_spacing", cyc - done_cyc, CS_HOLD + 1);
          check("bytes_per_frame", nbytes, 2);
          if (exp_q.size() == 0) begin
            check("frame_expected", exp_q.size(), 1);
          end else begin
            ev = exp_q.pop_front();
            check("frame_bytes", {b0, b1}, {8'(ev / 256), 8'(ev % 256)});
          end
          exp_cnt = (exp_cnt + 1) % 256;
          check("frame_cnt", frame_cnt, exp_cnt);
          n_frames++;
        end
        high_len   = sif.ss_n ? high_len + 1 : 0;
        prev_start = sif.tx_start;
        ss_prev    = sif.ss_n;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, base, bs, fr0, nb, k, bad_gap;
    logic        upd, clr;
    logic [13:0] v;

    repeat (3) @(negedge clk);
    check("rst_ss_n", sif.ss_n, 1);
    check("rst_tx_start", sif.tx_start, 0);
    check("rst_tx_data", sif.tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame, value 1234 -> 0x04, 0xD2.
    run = 1'b1; lat_lo = 80; lat_hi = 80;
    base = n_falls;
    do_load(1'b1, 1'b0, 14'd1234, t);
    wait_falls(base + 1); slot_full = 1'b0;
    check("upd_to_ss_n_fall", fall_cyc - t, 2);
    check("busy_in_frame", busy, 1);
    wait_drain();
    check("frame_cnt_single", frame_cnt, 1);
    check("busy_after_frame", busy, 0);

    // Coalescing: 6 then 7 during WAIT0 of value 5.
    base = n_falls; bs = n_starts;
    do_load(1'b1, 1'b0, 14'd5, t);
    wait_falls(base + 1); slot_full = 1'b0;
    wait_starts(bs + 1);
    do_load(1'b1, 1'b0, 14'd6, t);
    do_load(1'b1, 1'b0, 14'd7, t);
    wait_drain();
    check("coalesce_overrun", overrun, exp_ovr);
    pulse_ovr_clr(); exp_ovr = 1'b0;
    check("overrun_clr", overrun, exp_ovr);
    slot_full = 1'b0;

    // Clear beats a same-cycle update.
    base = n_falls;
    do_load(1'b1, 1'b1, 14'd9999, t);
    wait_falls(base + 1); slot_full = 1'b0;
    wait_drain();
    check("clear_prio_overrun", overrun, exp_ovr);

    // run=0: updates ignored, clear still framed.
    run = 1'b0; base = n_falls;
    do_load(1'b1, 1'b0, 14'd100, t);
    do_load(1'b1, 1'b0, 14'd200, t);
    repeat (40) @(negedge clk);
    check("run0_no_frame", n_falls, base);
    do_load(1'b0, 1'b1, 14'd0, t);
    wait_falls(base + 1); slot_full = 1'b0;
    wait_drain();
    check("run0_clear_frame", n_falls, base + 1);

    // Randomized updates, clears and mid-frame coalescing.
    lat_lo = 5; lat_hi = 20;
    for (int i = 0; i < 30; i++) begin
      run = ($urandom_range(3, 0) != 0);
      k   = $urandom_range(2, 0);
      upd = (k != 1);
      clr = (k != 0);
      v   = 14'($urandom_range(9999, 0));
      base = n_falls;
      do_load(upd, clr, v, t);
      if (clr || (upd && run)) begin
        wait_falls(base + 1); slot_full = 1'b0;
        nb = $urandom_range(3, 0);
        for (int j = 0; j < int'(nb); j++) begin
          k = $urandom_range(2, 0);
          do_load(k != 1, k == 2, 14'($urandom_range(9999, 0)), t);
        end
        wait_drain();
      end else begin
        repeat (30) @(negedge clk);
        check("ignored_update", n_falls, base);
      end
      check("rand_overrun", overrun, exp_ovr);
      if (exp_ovr) begin
        pulse_ovr_clr(); exp_ovr = 1'b0;
        check("rand_overrun_clr", overrun, exp_ovr);
      end
      slot_full = 1'b0;
    end

    // Reset asserted during WAIT1.
    run = 1'b1; lat_lo = 80; lat_hi = 80;
    base = n_falls; bs = n_starts;
    do_load(1'b1, 1'b0, 14'd4321, t);
    wait_falls(base + 1); slot_full = 1'b0;
    wait_starts(bs + 2);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_ss_n", sif.ss_n, 1);
    check("midrst_tx_start", sif.tx_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    exp_q.delete(); slot_full = 1'b0; exp_ovr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    base = n_falls;
    repeat (100) @(negedge clk);
    check("no_frame_after_reset", n_falls, base);
    check("ss_n_after_reset", sif.ss_n, 1);

    // 256 back-to-back frames: counter wraps, one idle cycle between frames.
    lat_lo = 1; lat_hi = 3;
    base = n_falls; bs = n_starts; fr0 = n_frames; bad_gap = 0;
    do_load(1'b1, 1'b0, 14'($urandom_range(9999, 0)), t);
    for (int i = 0; i < 256; i++) begin
      wait_falls(base + i + 1); slot_full = 1'b0;
      if (i > 0 && last_gap != 1) bad_gap++;
      if (i < 255) begin
        wait_starts(bs + 2 * i + 1);
        do_load(1'b1, 1'b0, 14'($urandom_range(9999, 0)), t);
      end
    end
    wait_drain();
    check("wrap_frames", n_frames - fr0, 256);
    check("wrap_frame_cnt", frame_cnt, 0);
    check("wrap_b2b_gap_errors", bad_gap, 0);
    check("wrap_overrun", overrun, exp_ovr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_sequencer.md
# spi_frame_sequencer

Sequencer between the master-side up counter and the SPI master byte engine. It snapshots each new 14-bit counter value and frames it as one two-byte SPI transaction, high byte then low byte, under a single `ss_n` assertion. It drives the engine with a start/done handshake and coalesces updates that arrive mid-frame. The slave decoder reassembles the value and drives the FND.

## Interface
- `CS_SETUP`, default 4: clk cycles `ss_n` is low before the first byte start; legal range 1..255.
- `BYTE_GAP`, default 2: idle clk cycles between byte 0 done and the byte 1 start; legal range 0..255.
- `CS_HOLD`, default 4: clk cycles `ss_n` stays low after the last done; legal range 1..255.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; when 0, counter updates are ignored.
- `clear`  in  1  one-cycle pulse; queues a frame carrying value 0, regardless of `run`.
- `value`  in  14  counter value, 0..9999.
- `value_upd`  in  1  one-cycle pulse; `value` is valid this cycle.
- `tx_data`  out  8  byte presented to the SPI engine.
- `tx_start`  out  1  one-cycle start pulse to the engine.
- `tx_done`  in  1  one-cycle pulse from the engine; byte shifted out.
- `ss_n`  out  1  slave select, active low.
- `busy`  out  1  high in every state except IDLE.
- `frame_cnt`  out  8  count of completed frames; wraps 255 -> 0.
- `overrun`  out  1  sticky; a pending value was overwritten before it was sent.
- `overrun_clr`  in  1  one-cycle pulse; clears `overrun`.

## Operation
- Reset values: `tx_data`=0, `tx_start`=0, `ss_n`=1, `busy`=0, `frame_cnt`=0, `overrun`=0, state=IDLE, pending=0.
- Pending register (`pend_val[13:0]`, `pend_flag`):
  - `value_upd & run`: load `value`, set `pend_flag`.
  - `clear`: load 0, set `pend_flag`. `clear` wins over a same-cycle `value_upd`.
  - Either load while `pend_flag` is already 1 and not being consumed this cycle: set `overrun`.
- Byte format:
  - byte 0 = `{2'b00, snap[13:8]}`.
  - byte 1 = `snap[7:0]`.
  - `snap` is captured from `pend_val` on leaving IDLE.
- FSM transitions:
  - IDLE: if `pend_flag`, capture `snap`, clear `pend_flag`, drive `ss_n`=0, go to SETUP. A same-cycle new load re-sets `pend_flag` and is not an overrun.
  - SETUP: count `CS_SETUP` cycles, then go to SEND0.
  - SEND0: `tx_data`=byte 0, `tx_start`=1 for exactly one cycle, go to WAIT0.
  - WAIT0: hold `tx_data`; on `tx_done` go to GAP, or straight to SEND1 if `BYTE_GAP`=0.
  - GAP: count `BYTE_GAP` cycles, then go to SEND1.
  - SEND1 / WAIT1: as SEND0 / WAIT0 with byte 1; on `tx_done` go to HOLD.
  - HOLD: count `CS_HOLD` cycles, then `ss_n`=1, increment `frame_cnt`, return to IDLE.
- `tx_done` outside WAIT0/WAIT1 is ignored.
- There is no timeout; the engine is required to return `tx_done`.
- Updates arriving during a frame never disturb `snap`. Only the latest value is kept; the next frame starts from IDLE.
- `overrun_clr` and a same-cycle overrun event: the set wins.
- `run` deasserting mid-frame does not abort the frame.
- Reset asserted mid-frame: all outputs and state go to their reset values immediately (async). `ss_n` rises without completing the frame.

## Timing
- Every output is registered.
- `value_upd` at cycle t with the FSM in IDLE:
  - `ss_n` falls at t+2 (t+1 latches pending, t+2 leaves IDLE).
  - first `tx_start` at t+2+`CS_SETUP`.
- `tx_start` is exactly one cycle wide; `tx_data` is stable from the `tx_start` cycle through the matching `tx_done`.
- Byte 1 `tx_start` comes `BYTE_GAP`+1 cycles after the byte 0 `tx_done` cycle.
- `ss_n` rises `CS_HOLD`+1 cycles after the byte 1 `tx_done`; `frame_cnt` updates in the same cycle.
- Minimum `ss_n` high time between back-to-back frames: 1 cycle (one IDLE cycle).

## Structure
- Package `spi_seq_pkg`:
  - `seq_state_t` enum (IDLE, SETUP, SEND0, WAIT0, GAP, SEND1, WAIT1, HOLD).
  - `VAL_W`=14.
  - `HI_PAD`=2'b00.
  - function `hi_byte(logic [13:0])`.
- One sub-module, `spi_seq_delay`: an 8-bit load/count-down timer with a `load` input and a `zero` output, shared by SETUP, GAP and HOLD.
- Instantiate inside the master top, between the up counter and the SPI master core.

## Test plan
- Single frame: `run`=1, `value_upd` with `value`=1234 (0x04D2); engine model returns `tx_done` 80 cycles after each start. Required:
  - bytes 0x04 then 0xD2 inside one `ss_n` low window.
  - `frame_cnt`=1.
  - SETUP/GAP/HOLD spacing is 4/2/4 cycles exactly.
- Coalescing: during WAIT0 of value 5, pulse `value_upd` with 6 and then 7. Required:
  - current frame sends 0x00/0x05.
  - next frame sends 0x00/0x07.
  - `overrun`=1, and `overrun_clr` returns it to 0.
- Clear priority: `clear` and `value_upd`(9999) in the same cycle. Required:
  - frame carries 0x00/0x00.
  - `overrun`=0.
- `run`=0: `value_upd` pulses produce no frames; `clear` still produces one frame of zeros.
- Reset mid-frame: assert `reset` low during WAIT1. Required:
  - same cycle: `ss_n`=1, `tx_start`=0, `busy`=0.
  - `frame_cnt`=0.
  - after release, no frame until a new update arrives.
- Wrap: 256 back-to-back frames -> `frame_cnt` reads 0; `ss_n` high for at least 1 cycle between every pair of frames.
